scale_sequencer: RTL and testbench

- Parametrised scale/octave selector driving the `scale` input of the key module in the piano top level.
- Holds a table of NUM_SCALES scale codes and keeps a current index into it.
- Index is stepped manually by debounced up/down buttons, or advanced automatically on a programmable period, in ramp or bounce order.
- Emits the selected scale code plus a one-cycle change strobe for the screen module.

---
 rtl/scale_sequencer_if.sv | 28 ++
 rtl/scale_sequencer.sv | 178 +++++++++++++++++
 tb/tb_scale_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scale_sequencer_if.sv
// Control/status bundle between the piano top level and scale_sequencer.
// The top level (master) drives the buttons and mode controls; the sequencer
// (slave) returns the selected scale code, its table index and the change strobe.
interface scale_sequencer_if #(
   parameter int NUM_SCALES = 5,
   parameter int SCALE_W    = 3
);
   localparam int IDX_W = (NUM_SCALES > 1) ? $clog2(NUM_SCALES) : 1;

   logic               btn_up;
   logic               btn_down;
   logic [1:0]         mode;
   logic               wrap_en;
   logic [SCALE_W-1:0] scale;
   logic [IDX_W-1:0]   index;
   logic               scale_chg;
   logic               dir;

   modport master (
      output btn_up, btn_down, mode, wrap_en,
      input  scale, index, scale_chg, dir
   );

   modport slave (
      input  btn_up, btn_down, mode, wrap_en,
      output scale, index, scale_chg, dir
   );
endinterface

// File: rtl/scale_sequencer.sv
// Scale/octave selector for the piano key module. Keeps an index into a
// table of scale codes, stepped by debounced up/down buttons or by a
// periodic timer in ramp or bounce order, and strobes scale_chg for the
// screen whenever the selected entry actually changes.
module scale_sequencer #(
   parameter int                              NUM_SCALES   = 5,
   parameter int                              SCALE_W      = 3,
   parameter logic [NUM_SCALES*SCALE_W-1:0]   SCALE_TABLE  = 15'b101_100_011_010_001,
   parameter int                              DEBOUNCE_CYC = 500000,
   parameter int                              AUTO_PERIOD  = 50000000
) (
   input logic              clk,
   input logic              reset_n,
   scale_sequencer_if.slave bus
);

   localparam int IDX_W = (NUM_SCALES > 1) ? $clog2(NUM_SCALES) : 1;
   localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int TMR_W = $clog2(AUTO_PERIOD);

   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_SCALES - 1);
   localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(AUTO_PERIOD - 1);
   localparam logic [SCALE_W-1:0] SCALE_RST = SCALE_TABLE[SCALE_W-1:0];

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_MANUAL = 2'b01,
      MODE_RAMP   = 2'b10,
      MODE_BOUNCE = 2'b11
   } mode_e;

   // Bit 0 of each button vector is btn_up, bit 1 is btn_down.
   logic [1:0]         sync1_q, sync2_q;
   logic [1:0]         level_q, level_d;
   logic [1:0]         press_q, press_d;
   logic [DB_W-1:0]    dbCnt_q [2];
   logic [DB_W-1:0]    dbCnt_d [2];
   logic [TMR_W-1:0]   timer_q, timer_d;
   mode_e              modePrev_q, modePrev_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic [SCALE_W-1:0] scale_q, scale_d;
   logic               scaleChg_q, scaleChg_d;
   logic               dir_q, dir_d;

   mode_e              modeNow;
   logic               modeChg;
   logic               tick;
   logic               upPress;
   logic               downPress;

   // Table lookup with explicit compares so an index outside the table
   // can never select bits beyond the packed parameter.
   function automatic logic [SCALE_W-1:0] tableEntry(input logic [IDX_W-1:0] idx);
      logic [SCALE_W-1:0] entry;
      entry = SCALE_RST;
      for (int i = 0; i < NUM_SCALES; i++) begin
         if (idx == IDX_W'(i)) entry = SCALE_TABLE[i*SCALE_W +: SCALE_W];
      end
      return entry;
   endfunction

   // Two-flop synchronisers bring the raw asynchronous buttons into clk.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {bus.btn_down, bus.btn_up};
         sync2_q <= sync1_q;
      end
   end

   // Debounce, mode tracking, timer and index/scale next-state.
   always_comb begin
      level_d    = level_q;
      press_d    = '0;
      dbCnt_d[0] = '0;
      dbCnt_d[1] = '0;
      modeNow    = mode_e'(bus.mode);
      modePrev_d = modeNow;
      modeChg    = (modeNow != modePrev_q);
      index_d    = index_q;
      dir_d      = dir_q;
      timer_d    = '0;

      // A level is accepted on the DEBOUNCE_CYC-th consecutive disagreeing
      // cycle; only the 0->1 acceptance produces a press pulse.
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] != level_q[b]) begin
            if (dbCnt_q[b] == DB_LAST) begin
               level_d[b] = sync2_q[b];
               press_d[b] = sync2_q[b];
            end else begin
               dbCnt_d[b] = dbCnt_q[b] + DB_W'(1);
            end
         end
      end

      upPress   = press_q[0] & ~press_q[1];
      downPress = press_q[1] & ~press_q[0];
      tick      = ((modeNow == MODE_RAMP) || (modeNow == MODE_BOUNCE)) && (timer_q == TMR_LAST);

      // The timer only runs in the auto modes, and restarts whenever the
      // mode value moves so a new mode always gets a full period.
      if ((modeNow == MODE_RAMP || modeNow == MODE_BOUNCE) && !modeChg && (timer_q != TMR_LAST)) begin
         timer_d = timer_q + TMR_W'(1);
      end

      case (modeNow)
         MODE_MANUAL: begin
            if (upPress) begin
               if (index_q == LAST_IDX) begin
                  if (bus.wrap_en) index_d = '0;
               end else begin
                  index_d = index_q + IDX_W'(1);
               end
            end else if (downPress) begin
               if (index_q == '0) begin
                  if (bus.wrap_en) index_d = LAST_IDX;
               end else begin
                  index_d = index_q - IDX_W'(1);
               end
            end
         end
         MODE_RAMP: begin
            if (tick) index_d = (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
         end
         MODE_BOUNCE: begin
            // With a single entry there is nowhere to bounce, so nothing moves.
            // An index already at the far end turns around instead of running off.
            if (tick && (NUM_SCALES > 1)) begin
               if (dir_q) index_d = (index_q == LAST_IDX) ? index_q - IDX_W'(1) : index_q + IDX_W'(1);
               else       index_d = (index_q == '0)      ? index_q + IDX_W'(1) : index_q - IDX_W'(1);
               if (index_d == LAST_IDX)  dir_d = 1'b0;
               else if (index_d == '0)   dir_d = 1'b1;
            end
         end
         default: ;
      endcase

      scale_d    = tableEntry(index_d);
      scaleChg_d = (index_d != index_q);
   end

   // State registers for debouncers, timer and the selected entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q    <= '0;
         press_q    <= '0;
         dbCnt_q[0] <= '0;
         dbCnt_q[1] <= '0;
         timer_q    <= '0;
         modePrev_q <= MODE_HOLD;
         index_q    <= '0;
         scale_q    <= SCALE_RST;
         scaleChg_q <= 1'b0;
         dir_q      <= 1'b1;
      end else begin
         level_q    <= level_d;
         press_q    <= press_d;
         dbCnt_q[0] <= dbCnt_d[0];
         dbCnt_q[1] <= dbCnt_d[1];
         timer_q    <= timer_d;
         modePrev_q <= modePrev_d;
         index_q    <= index_d;
         scale_q    <= scale_d;
         scaleChg_q <= scaleChg_d;
         dir_q      <= dir_d;
      end
   end

   assign bus.scale     = scale_q;
   assign bus.index     = index_q;
   assign bus.scale_chg = scaleChg_q;
   assign bus.dir       = dir_q;

endmodule

// File: tb/tb_scale_sequencer.sv
// Testbench for scale_sequencer with short debounce and auto periods.
// A behavioural model predicts every index change; the predictions are
// queued and a negedge monitor checks them against scale_chg.
module tb_scale_sequencer;

   localparam int N = 5;
   localparam int D = 4;
   localparam int P = 8;

   logic clk = 1'b0;
   logic reset_n;

   scale_sequencer_if #(.NUM_SCALES(N), .SCALE_W(3)) bus ();

   scale_sequencer #(
      .NUM_SCALES  (N),
      .SCALE_W     (3),
      .DEBOUNCE_CYC(D),
      .AUTO_PERIOD (P)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int idx;
      int scl;
      bit dirv;
   } exp_t;

   exp_t expQ[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cycle      = 0;
   bit   started    = 0;

   // Reference model state: selected index, bounce direction, auto timer,
   // and for each button a 2-cycle delay line, disagreement run and level.
   int   mIdx      = 0;
   bit   mDir      = 1;
   int   mTimer    = 0;
   int   mPrevMode = 0;
   bit   dlyA [2];
   bit   dlyB [2];
   int   run  [2];
   bit   lvl  [2];
   bit   press[2];

   task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
      compared++;
      if (actual !== 32'(expected)) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Model: inputs seen during the cycle decide what happens at this edge.
   always @(posedge clk) begin : model
      int newIdx;
      bit newDir;
      int md;
      bit raw [2];
      bit delivered;
      cycle++;
      raw[0] = bus.btn_up;
      raw[1] = bus.btn_down;
      md     = int'(bus.mode);
      if (!reset_n) begin
         mIdx = 0; mDir = 1; mTimer = 0; mPrevMode = 0;
         for (int b = 0; b < 2; b++) begin
            dlyA[b] = 0; dlyB[b] = 0; run[b] = 0; lvl[b] = 0; press[b] = 0;
         end
      end else begin
         newIdx = mIdx;
         newDir = mDir;
         if (md == 1) begin
            if (press[0] && !press[1])
               newIdx = (mIdx < N - 1) ? mIdx + 1 : (bus.wrap_en ? 0 : mIdx);
            else if (press[1] && !press[0])
               newIdx = (mIdx > 0) ? mIdx - 1 : (bus.wrap_en ? N - 1 : mIdx);
         end else if (md >= 2 && mTimer == P - 1) begin
            if (md == 2) begin
               newIdx = (mIdx + 1) % N;
            end else begin
               newIdx = mDir ? mIdx + 1 : mIdx - 1;
               if (newIdx > N - 1) newIdx = N - 2;
               if (newIdx < 0)     newIdx = 1;
               if (newIdx == N - 1)  newDir = 0;
               else if (newIdx == 0) newDir = 1;
            end
         end
         if (newIdx != mIdx) expQ.push_back('{cyc: cycle, idx: newIdx, scl: newIdx + 1, dirv: newDir});
         mIdx = newIdx;
         mDir = newDir;
         mTimer = (md < 2 || md != mPrevMode || mTimer == P - 1) ? 0 : mTimer + 1;
         mPrevMode = md;
         for (int b = 0; b < 2; b++) begin
            delivered = dlyB[b];
            dlyB[b]   = dlyA[b];
            dlyA[b]   = raw[b];
            press[b]  = 0;
            if (delivered != lvl[b]) begin
               run[b]++;
               if (run[b] == D) begin
                  lvl[b]   = delivered;
                  run[b]   = 0;
                  press[b] = delivered;
               end
            end else begin
               run[b] = 0;
            end
         end
      end
   end

   // Monitor: pops the prediction due this cycle and compares everything.
   always @(negedge clk) begin : monitor
      bit   expChg;
      exp_t e;
      if (started) begin
         expChg = (expQ.size() > 0) && (expQ[0].cyc == cycle);
         checkOutput("scale_chg", 32'(bus.scale_chg), int'(expChg));
         if (expChg) begin
            e = expQ.pop_front();
            checkOutput("chg_index", 32'(bus.index), e.idx);
            checkOutput("chg_scale", 32'(bus.scale), e.scl);
            checkOutput("chg_dir",   32'(bus.dir),   int'(e.dirv));
         end
         checkOutput("index", 32'(bus.index), mIdx);
         checkOutput("scale", 32'(bus.scale), mIdx + 1);
         checkOutput("dir",   32'(bus.dir),   int'(mDir));
      end
   end

   task automatic applyStimulus(input bit up, input bit dn, input int cycles);
      bus.btn_up   = up;
      bus.btn_down = dn;
      repeat (cycles) @(negedge clk);
   endtask

   // Waits up to maxCyc cycles for scale_chg; lat counts edges waited.
   task automatic waitChg(input int maxCyc, input bit jitter, output bit got,
                          output int lat, output int scl, output bit dv);
      got = 0; lat = 0; scl = 0; dv = 0;
      for (int i = 1; i <= maxCyc; i++) begin
         @(negedge clk);
         if (jitter) begin
            bus.btn_up   = 1'($urandom_range(0, 1));
            bus.btn_down = 1'($urandom_range(0, 1));
         end
         if (bus.scale_chg === 1'b1) begin
            got = 1; lat = i; scl = int'(bus.scale); dv = bus.dir;
            break;
         end
      end
   endtask

   // One full press: 8 cycles held, 8 released; reports any change seen.
   task automatic pressBtn(input bit up, input bit dn, output bit saw, output int scl);
      saw = 0; scl = 0;
      bus.btn_up = up; bus.btn_down = dn;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.scale_chg === 1'b1) begin saw = 1; scl = int'(bus.scale); end
         if (i == 7) begin bus.btn_up = 0; bus.btn_down = 0; end
      end
   endtask

   initial begin : guard
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected finish before 500000");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      bit got, dv, saw;
      int lat, scl, held;
      int rampExp   [6] = '{2, 3, 4, 5, 1, 2};
      int bounceExp [9] = '{2, 3, 4, 5, 4, 3, 2, 1, 2};
      bit bounceDir [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};

      reset_n = 0; bus.btn_up = 0; bus.btn_down = 0; bus.mode = 2'b01; bus.wrap_en = 0;
      @(negedge clk);
      started = 1;
      repeat (2) @(negedge clk);
      checkOutput("rst_index", 32'(bus.index), 0);
      checkOutput("rst_scale", 32'(bus.scale), 1);
      checkOutput("rst_chg",   32'(bus.scale_chg), 0);
      checkOutput("rst_dir",   32'(bus.dir), 1);
      reset_n = 1;
      applyStimulus(0, 0, 3);

      $display("[TB] manual debounce");
      applyStimulus(1, 0, 3);
      bus.btn_up = 0;
      waitChg(15, 0, got, lat, scl, dv);
      checkOutput("short_press_ignored", 32'(got), 0);
      bus.btn_up = 1;
      waitChg(20, 0, got, lat, scl, dv);
      checkOutput("press_seen", 32'(got), 1);
      checkOutput("press_latency", 32'(lat), 2 + D + 1);
      checkOutput("press_scale", 32'(scl), 2);
      applyStimulus(1, 0, 10 - lat);
      bus.btn_up = 0;
      waitChg(15, 0, got, lat, scl, dv);
      checkOutput("single_step", 32'(got), 0);
      applyStimulus(1, 1, 10);
      bus.btn_up = 0; bus.btn_down = 0;
      waitChg(15, 0, got, lat, scl, dv);
      checkOutput("both_buttons", 32'(got), 0);

      $display("[TB] manual ends");
      for (int k = 0; k < 3; k++) begin
         pressBtn(1, 0, saw, scl);
         checkOutput("climb_scale", 32'(scl), k + 3);
      end
      pressBtn(1, 0, saw, scl);
      checkOutput("sat_top_no_chg", 32'(saw), 0);
      checkOutput("sat_top_scale", 32'(bus.scale), 5);
      bus.wrap_en = 1;
      pressBtn(1, 0, saw, scl);
      checkOutput("wrap_top_scale", 32'(scl), 1);
      checkOutput("wrap_top_index", 32'(bus.index), 0);
      pressBtn(0, 1, saw, scl);
      checkOutput("wrap_bot_scale", 32'(scl), 5);
      checkOutput("wrap_bot_index", 32'(bus.index), 4);

      $display("[TB] random manual");
      for (int k = 0; k < 25; k++) begin
         bus.wrap_en = 1'($urandom_range(0, 1));
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
      end

      $display("[TB] auto ramp");
      reset_n = 0; bus.mode = 2'b10; bus.btn_up = 0; bus.btn_down = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      for (int k = 0; k < 6; k++) begin
         waitChg(30, 1, got, lat, scl, dv);
         checkOutput("ramp_scale", 32'(scl), rampExp[k]);
         if (k > 0) checkOutput("ramp_period", 32'(lat), P);
      end
      bus.btn_up = 0; bus.btn_down = 0;

      $display("[TB] mode change mid period");
      repeat (5) @(negedge clk);
      bus.mode = 2'b11;
      waitChg(30, 0, got, lat, scl, dv);
      checkOutput("modechg_latency", 32'(lat), P + 1);
      checkOutput("modechg_scale", 32'(scl), 3);

      $display("[TB] reset mid ramp");
      bus.mode = 2'b10;
      repeat (13) @(negedge clk);
      reset_n = 0; bus.mode = 2'b11;
      @(negedge clk);
      checkOutput("midrst_index", 32'(bus.index), 0);
      checkOutput("midrst_scale", 32'(bus.scale), 1);
      checkOutput("midrst_chg",   32'(bus.scale_chg), 0);
      checkOutput("midrst_dir",   32'(bus.dir), 1);
      reset_n = 1;

      $display("[TB] auto bounce");
      for (int k = 0; k < 9; k++) begin
         waitChg(30, 1, got, lat, scl, dv);
         checkOutput("bounce_scale", 32'(scl), bounceExp[k]);
         checkOutput("bounce_dir", 32'(dv), int'(bounceDir[k]));
         if (k > 0) checkOutput("bounce_period", 32'(lat), P);
      end

      $display("[TB] hold");
      bus.mode = 2'b00;
      held = int'(bus.index);
      waitChg(40, 1, got, lat, scl, dv);
      checkOutput("hold_no_chg", 32'(got), 0);
      checkOutput("hold_index", 32'(bus.index), held);

      $display("[TB] random modes");
      for (int k = 0; k < 30; k++) begin
         bus.mode    = 2'($urandom_range(0, 3));
         bus.wrap_en = 1'($urandom_range(0, 1));
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(5, 25));
      end

      bus.mode = 2'b00;
      applyStimulus(0, 0, 10);
      checkOutput("queue_drained", 32'(expQ.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
